// File: rtl/sha256_pkg.sv
// SHA-256 constants, shared types and round helper functions.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [0:7][31:0]  state_t;   // a..h, element 0 = a
  typedef logic [0:15][31:0] sched_t;   // schedule window, element 0 = oldest word

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Feed-forward of the initial hash into the final working state.
  function automatic state_t add_iv(input state_t s);
    state_t r;
    for (int i = 0; i < 8; i++) r[i] = s[i] + IV[i];
    return r;
  endfunction

endpackage

// File: rtl/sha256_512_if.sv
// Block-in / digest-out bus of the SHA-256 engine (no backpressure).
interface sha256_512_if;
  logic         valid;
  logic [511:0] msg_in;
  logic         validout;
  logic [255:0] final_out;

  modport master (output valid, msg_in, input validout, final_out);
  modport slave  (input valid, msg_in, output validout, final_out);
endinterface

// File: rtl/sha256_round.sv
// One registered SHA-256 round: working state, schedule window and valid bit.
module sha256_round
  import sha256_pkg::*;
#(
  parameter word_t K_R = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_i,
  input  state_t state_i,
  input  sched_t sched_i,
  output logic   valid_o,
  output state_t state_o,
  output sched_t sched_o
);

  word_t  t1, t2, w_new;
  state_t state_nxt;
  sched_t sched_nxt;

  // Round function plus the schedule extension for word t+16.
  always_comb begin
    t1 = state_i[7] + big_sigma1(state_i[4]) + ch(state_i[4], state_i[5], state_i[6])
         + K_R + sched_i[0];
    t2 = big_sigma0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);
    state_nxt = {t1 + t2, state_i[0], state_i[1], state_i[2],
                 state_i[3] + t1, state_i[4], state_i[5], state_i[6]};
    w_new = small_sigma1(sched_i[14]) + sched_i[9] + small_sigma0(sched_i[1]) + sched_i[0];
    sched_nxt = {sched_i[1:15], w_new};
  end

  // Stage register; datapath advances every cycle, valid tags the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      state_o <= '0;
      sched_o <= '0;
    end else begin
      valid_o <= valid_i;
      state_o <= state_nxt;
      sched_o <= sched_nxt;
    end
  end

endmodule

// File: rtl/sha256_512_top.sv
// Fully pipelined single-block SHA-256: input stage, 64 round stages, IV add.
// Optional macro SHA256_OUTREG_EN adds one register after the IV add
// (latency 66 edges instead of 65).
module sha256_512_top
  import sha256_pkg::*;
(
  input  logic clk,
  input  logic rst,
  sha256_512_if.slave bus
);

  localparam int ROUNDS = 64;

  logic   vld [0:ROUNDS];
  state_t st  [0:ROUNDS];
  sched_t ws  [0:ROUNDS];
  state_t digest;

  // Input stage: capture the block and start every block from the IV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld[0] <= 1'b0;
      st[0]  <= '0;
      ws[0]  <= '0;
    end else begin
      vld[0] <= bus.valid;
      st[0]  <= IV;
      ws[0]  <= bus.msg_in;
    end
  end

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    sha256_round #(.K_R(K[r])) u_round (
      .clk     (clk),
      .rst     (rst),
      .valid_i (vld[r]),
      .state_i (st[r]),
      .sched_i (ws[r]),
      .valid_o (vld[r+1]),
      .state_o (st[r+1]),
      .sched_o (ws[r+1])
    );
  end

  assign digest = add_iv(st[ROUNDS]);

`ifdef SHA256_OUTREG_EN
  logic   sum_vld;
  state_t sum_q;

  // Retime the IV add away from the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_vld <= 1'b0;
      sum_q   <= '0;
    end else begin
      sum_vld <= vld[ROUNDS];
      sum_q   <= digest;
    end
  end

  // Output register; digest held between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.validout  <= 1'b0;
      bus.final_out <= '0;
    end else begin
      bus.validout <= sum_vld;
      if (sum_vld) bus.final_out <= sum_q;
    end
  end
`else
  // Output register; digest held between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.validout  <= 1'b0;
      bus.final_out <= '0;
    end else begin
      bus.validout <= vld[ROUNDS];
      if (vld[ROUNDS]) bus.final_out <= digest;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_512_top.sv
// Directed bench for sha256_512_top: known digests, ordering, gaps, latency, reset.
module tb_sha256_512_top;

`ifdef SHA256_OUTREG_EN
  localparam int LAT = 66;
`else
  localparam int LAT = 65;
`endif

  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk;
  logic rst;
  sha256_512_if bus ();

  sha256_512_top dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pcyc [$];
  logic [255:0] pdig [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every output pulse with the edge count it followed.
  always @(negedge clk) begin
    if (bus.validout) begin
      pcyc.push_back(cyc);
      pdig.push_back(bus.final_out);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one block for one cycle; n is the accepting edge number.
  task automatic issue(input logic [511:0] m, output int n);
    bus.valid  = 1'b1;
    bus.msg_in = m;
    n = cyc + 1;
    @(negedge clk);
    bus.valid  = 1'b0;
    bus.msg_in = '0;
  endtask

  task automatic clear_log();
    pcyc.delete();
    pdig.delete();
  endtask

  int n0, n1, n2;

  initial begin
    rst        = 1'b0;
    bus.valid  = 1'b0;
    bus.msg_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_validout", 256'(bus.validout), 256'd0);
    chk("reset_final", bus.final_out, 256'd0);
    rst = 1'b1;
    @(negedge clk);

    // single "abc"
    clear_log();
    issue(MSG_ABC, n0);
    repeat (LAT + 8) @(negedge clk);
    chk("abc_count", 256'(pcyc.size()), 256'd1);
    if (pcyc.size() >= 1) begin
      chk("abc_digest", pdig[0], DIG_ABC);
      chk("abc_latency", 256'(pcyc[0] - n0), 256'(LAT));
    end
    chk("abc_hold", bus.final_out, DIG_ABC);

    // empty message
    clear_log();
    issue(MSG_EMPTY, n0);
    repeat (LAT + 8) @(negedge clk);
    chk("empty_count", 256'(pcyc.size()), 256'd1);
    if (pcyc.size() >= 1) begin
      chk("empty_digest", pdig[0], DIG_EMPTY);
      chk("empty_latency", 256'(pcyc[0] - n0), 256'(LAT));
    end

    // back-to-back abc, empty, abc
    clear_log();
    issue(MSG_ABC, n0);
    issue(MSG_EMPTY, n1);
    issue(MSG_ABC, n2);
    repeat (LAT + 8) @(negedge clk);
    chk("b2b_count", 256'(pcyc.size()), 256'd3);
    if (pcyc.size() >= 3) begin
      chk("b2b_dig0", pdig[0], DIG_ABC);
      chk("b2b_dig1", pdig[1], DIG_EMPTY);
      chk("b2b_dig2", pdig[2], DIG_ABC);
      chk("b2b_lat0", 256'(pcyc[0] - n0), 256'(LAT));
      chk("b2b_step1", 256'(pcyc[1] - pcyc[0]), 256'd1);
      chk("b2b_step2", 256'(pcyc[2] - pcyc[1]), 256'd1);
    end

    // empty, three idle cycles, abc
    clear_log();
    issue(MSG_EMPTY, n0);
    repeat (3) @(negedge clk);
    issue(MSG_ABC, n1);
    repeat (LAT + 8) @(negedge clk);
    chk("gap_count", 256'(pcyc.size()), 256'd2);
    if (pcyc.size() >= 2) begin
      chk("gap_dig0", pdig[0], DIG_EMPTY);
      chk("gap_dig1", pdig[1], DIG_ABC);
      chk("gap_spacing", 256'(pcyc[1] - pcyc[0]), 256'd4);
      chk("gap_lat1", 256'(pcyc[1] - n1), 256'(LAT));
    end

    // reset while a block is in flight; valid during reset is ignored
    issue(MSG_ABC, n0);
    repeat (19) @(negedge clk);
    clear_log();
    rst = 1'b0;
    #1;
    chk("rst_validout", 256'(bus.validout), 256'd0);
    chk("rst_final", bus.final_out, 256'd0);
    bus.valid  = 1'b1;
    bus.msg_in = MSG_ABC;
    @(negedge clk);
    bus.valid  = 1'b0;
    bus.msg_in = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 20) @(negedge clk);
    chk("rst_stale_count", 256'(pcyc.size()), 256'd0);
    chk("rst_final_after", bus.final_out, 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
